// File: rtl/baser_test_sequencer.sv
// BASE-R loop self-test controller: clears the checker, steps the generator through a
// fixed 14-step enable/MII schedule, drains, then latches checker counters and a verdict.
module baser_test_sequencer #(
  parameter int DATA_WIDTH        = 64,
  parameter int CONTROL_WIDTH     = 8,
  parameter int TRANSCODER_BLOCKS = 4,
  parameter int PHASE_CYCLES      = 30,
  parameter int CLEAR_CYCLES      = 2,
  parameter int DRAIN_CYCLES      = 8,
  parameter int MIN_BLOCKS        = 32
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [31:0]                  i_block_count,
  input  logic [31:0]                  i_inv_block_count,
  output logic                         o_ckr_rst,
  output logic                         o_enable,
  output logic [1:0]                   o_valid,
  output logic [TRANSCODER_BLOCKS-1:0] o_data_sel,
  output logic [DATA_WIDTH-1:0]        o_txd,
  output logic [CONTROL_WIDTH-1:0]     o_txc,
  output logic [3:0]                   o_step,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_pass,
  output logic                         o_aborted,
  output logic [31:0]                  o_blocks_seen,
  output logic [31:0]                  o_inv_seen
);

  localparam int unsigned MAX_CYC =
    (PHASE_CYCLES > CLEAR_CYCLES)
      ? ((PHASE_CYCLES > DRAIN_CYCLES) ? PHASE_CYCLES : DRAIN_CYCLES)
      : ((CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES);
  localparam int unsigned CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] PHASE_LD = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_EVAL, S_DONE} state_t;

  state_t                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [3:0]                     step_q;
  logic                           ckr_rst_q, enable_q, busy_q, done_q, pass_q, aborted_q;
  logic [1:0]                     valid_q;
  logic [TRANSCODER_BLOCKS-1:0]   sel_q;
  logic [DATA_WIDTH-1:0]          txd_q;
  logic [CONTROL_WIDTH-1:0]       txc_q;
  logic [31:0]                    blocks_q, inv_q;

  // Stimulus for the step about to be entered (step 0 when leaving CLEAR).
  logic [3:0]                     nstep;
  logic [TRANSCODER_BLOCKS-1:0]   sel_nx;
  logic [DATA_WIDTH-1:0]          txd_nx;
  logic [CONTROL_WIDTH-1:0]       txc_nx;

  assign nstep = (state_q == S_RUN) ? step_q + 4'd1 : 4'd0;

  always_comb begin
    sel_nx = TRANSCODER_BLOCKS'(4'hF);
    txd_nx = '0;
    txc_nx = '0;
    case (nstep)
      4'd0:  sel_nx = TRANSCODER_BLOCKS'(4'h0);
      4'd1:  sel_nx = TRANSCODER_BLOCKS'(4'h1);
      4'd2:  sel_nx = TRANSCODER_BLOCKS'(4'h2);
      4'd3:  sel_nx = TRANSCODER_BLOCKS'(4'h3);
      4'd4:  sel_nx = TRANSCODER_BLOCKS'(4'h4);
      4'd5:  sel_nx = TRANSCODER_BLOCKS'(4'h8);
      4'd7:  txd_nx = DATA_WIDTH'(64'hFFFFFFFFFFFFFFFF);
      4'd8:  txd_nx = DATA_WIDTH'(64'hAAAAAAAAAAAAAAAA);
      4'd9:  begin txd_nx = DATA_WIDTH'(64'h07070707070707FD); txc_nx = CONTROL_WIDTH'(8'hFF); end
      4'd10: begin txd_nx = DATA_WIDTH'(64'hAAAAAAAAAAAAAAFB); txc_nx = CONTROL_WIDTH'(8'h01); end
      4'd11: txd_nx = DATA_WIDTH'(64'hAAAAAAAAAAAAAAAA);
      4'd12: begin txd_nx = DATA_WIDTH'(64'h0707070707FDAAAA); txc_nx = CONTROL_WIDTH'(8'hFC); end
      4'd13: begin txd_nx = DATA_WIDTH'(64'h0707070707070707); txc_nx = CONTROL_WIDTH'(8'hFF); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      ckr_rst_q <= 1'b1;
      enable_q  <= 1'b0;
      valid_q   <= '0;
      sel_q     <= '0;
      txd_q     <= '0;
      txc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
      blocks_q  <= '0;
      inv_q     <= '0;
    end else if (state_q == S_IDLE || state_q == S_DONE) begin
      ckr_rst_q <= 1'b0;
      if (i_start && !i_abort) begin
        state_q   <= S_CLEAR;
        cnt_q     <= CLEAR_LD;
        step_q    <= '0;
        ckr_rst_q <= 1'b1;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        pass_q    <= 1'b0;
        aborted_q <= 1'b0;
        blocks_q  <= '0;
        inv_q     <= '0;
      end
    end else if (i_abort) begin
      state_q   <= S_DONE;
      step_q    <= '0;
      ckr_rst_q <= 1'b0;
      enable_q  <= 1'b0;
      valid_q   <= '0;
      sel_q     <= '0;
      txd_q     <= '0;
      txc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b1;
      pass_q    <= 1'b0;
      aborted_q <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == '0) begin
            state_q   <= S_RUN;
            cnt_q     <= PHASE_LD;
            step_q    <= nstep;
            ckr_rst_q <= 1'b0;
            enable_q  <= 1'b1;
            valid_q   <= 2'b11;
            sel_q     <= sel_nx;
            txd_q     <= txd_nx;
            txc_q     <= txc_nx;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (step_q == 4'd13) begin
            state_q <= S_DRAIN;
            cnt_q   <= DRAIN_LD;
          end else begin
            cnt_q    <= PHASE_LD;
            step_q   <= nstep;
            enable_q <= (nstep < 4'd7);
            sel_q    <= sel_nx;
            txd_q    <= txd_nx;
            txc_q    <= txc_nx;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) state_q <= S_EVAL;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_EVAL: begin
          state_q  <= S_DONE;
          step_q   <= '0;
          enable_q <= 1'b0;
          valid_q  <= '0;
          sel_q    <= '0;
          txd_q    <= '0;
          txc_q    <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          blocks_q <= i_block_count;
          inv_q    <= i_inv_block_count;
          pass_q   <= (i_inv_block_count == 32'd0) && (i_block_count >= 32'(MIN_BLOCKS));
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ckr_rst     = ckr_rst_q;
  assign o_enable      = enable_q;
  assign o_valid       = valid_q;
  assign o_data_sel    = sel_q;
  assign o_txd         = txd_q;
  assign o_txc         = txc_q;
  assign o_step        = step_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_aborted     = aborted_q;
  assign o_blocks_seen = blocks_q;
  assign o_inv_seen    = inv_q;

endmodule

// File: tb/tb_baser_test_sequencer.sv
// Directed bench for baser_test_sequencer with PHASE=4, CLEAR=2, DRAIN=8 (done 67 edges after start).
module tb_baser_test_sequencer;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_block_count = '0;
  logic [31:0] i_inv_block_count = '0;
  logic        o_ckr_rst, o_enable, o_busy, o_done, o_pass, o_aborted;
  logic [1:0]  o_valid;
  logic [3:0]  o_data_sel;
  logic [63:0] o_txd;
  logic [7:0]  o_txc;
  logic [3:0]  o_step;
  logic [31:0] o_blocks_seen, o_inv_seen;

  int checks = 0;
  int errors = 0;

  logic [3:0]  sel_tab [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hF,
                                4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [7:0]  txc_tab [14] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'hFC, 8'hFF};
  logic [63:0] txd_tab [14] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                                64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA,
                                64'h07070707070707FD, 64'hAAAAAAAAAAAAAAFB,
                                64'hAAAAAAAAAAAAAAAA, 64'h0707070707FDAAAA,
                                64'h0707070707070707};

  baser_test_sequencer #(
    .DATA_WIDTH(64), .CONTROL_WIDTH(8), .TRANSCODER_BLOCKS(4),
    .PHASE_CYCLES(4), .CLEAR_CYCLES(2), .DRAIN_CYCLES(8), .MIN_BLOCKS(32)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_block_count(i_block_count), .i_inv_block_count(i_inv_block_count),
    .o_ckr_rst(o_ckr_rst), .o_enable(o_enable), .o_valid(o_valid),
    .o_data_sel(o_data_sel), .o_txd(o_txd), .o_txc(o_txc), .o_step(o_step),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_aborted(o_aborted),
    .o_blocks_seen(o_blocks_seen), .o_inv_seen(o_inv_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_enable"}, 64'(o_enable), 64'd0);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_sel"}, 64'(o_data_sel), 64'd0);
    check({tag, "_txd"}, o_txd, 64'd0);
    check({tag, "_txc"}, 64'(o_txc), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  // One run from a start pulse. abort_k < 0 means no abort; otherwise i_abort is
  // raised after edge abort_k. inv_eval is presented only during EVAL.
  task automatic run(input logic [31:0] blk, input logic [31:0] inv_eval,
                     input int abort_k, input bit exp_pass, input bit sched);
    i_block_count     = blk;
    i_inv_block_count = '0;
    @(negedge clk);
    i_start = 1'b1;
    for (int k = 0; k <= 67; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        i_start = 1'b0;
        check("start_busy", 64'(o_busy), 64'd1);
        check("start_ckr_rst", 64'(o_ckr_rst), 64'd1);
        check("start_done_clr", 64'(o_done), 64'd0);
        check("start_abort_clr", 64'(o_aborted), 64'd0);
        check("start_pass_clr", 64'(o_pass), 64'd0);
        check("start_blk_clr", 64'(o_blocks_seen), 64'd0);
      end
      if (k == 1) check("clear_hold", 64'(o_ckr_rst), 64'd1);
      if (k == 2) check("clear_end", 64'(o_ckr_rst), 64'd0);
      if (k == 20) i_start = 1'b1;
      if (k == 21) i_start = 1'b0;
      if (sched && k >= 2 && k < 58 && ((k - 2) % 4) == 0) begin
        int s;
        s = (k - 2) / 4;
        check($sformatf("step%0d", s), 64'(o_step), 64'(s));
        check($sformatf("sel%0d", s), 64'(o_data_sel), 64'(sel_tab[s]));
        check($sformatf("txd%0d", s), o_txd, txd_tab[s]);
        check($sformatf("txc%0d", s), 64'(o_txc), 64'(txc_tab[s]));
        check($sformatf("en%0d", s), 64'(o_enable), (s < 7) ? 64'd1 : 64'd0);
        check($sformatf("valid%0d", s), 64'(o_valid), 64'd3);
      end
      if (sched && k == 5) check("step0_last", 64'(o_step), 64'd0);
      if (sched && k == 65) begin
        check("drain_step", 64'(o_step), 64'd13);
        check("drain_txd", o_txd, 64'h0707070707070707);
      end
      if (k == abort_k) i_abort = 1'b1;
      if (abort_k >= 0 && k == abort_k + 1) begin
        i_abort = 1'b0;
        check("abort_done", 64'(o_done), 64'd1);
        check("abort_flag", 64'(o_aborted), 64'd1);
        check("abort_pass", 64'(o_pass), 64'd0);
        check("abort_blk", 64'(o_blocks_seen), 64'd0);
        check("abort_ckr", 64'(o_ckr_rst), 64'd0);
        check_idle_outputs("abort");
        return;
      end
      if (k == 66) begin
        check("eval_not_done", 64'(o_done), 64'd0);
        check("eval_busy", 64'(o_busy), 64'd1);
        i_inv_block_count = inv_eval;
      end
      if (k == 67) begin
        i_inv_block_count = '0;
        check("done", 64'(o_done), 64'd1);
        check("pass", 64'(o_pass), 64'(exp_pass));
        check("blocks_seen", 64'(o_blocks_seen), 64'(blk));
        check("inv_seen", 64'(o_inv_seen), 64'(inv_eval));
        check("aborted", 64'(o_aborted), 64'd0);
        check("done_step", 64'(o_step), 64'd0);
        check_idle_outputs("done");
      end
    end
  endtask

  initial begin
    #12;
    check("rst_ckr_rst", 64'(o_ckr_rst), 64'd1);
    check("rst_step", 64'(o_step), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_pass", 64'(o_pass), 64'd0);
    check_idle_outputs("rst");
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_release_ckr", 64'(o_ckr_rst), 64'd0);

    run(32'd100, 32'd0, -1, 1'b1, 1'b1);   // clean run with schedule and ignored start
    run(32'd100, 32'd3, -1, 1'b0, 1'b0);   // invalid blocks at EVAL
    run(32'd5,   32'd0, -1, 1'b0, 1'b0);   // too few blocks
    run(32'd32,  32'd0, -1, 1'b1, 1'b0);   // exactly MIN_BLOCKS
    run(32'd31,  32'd0, -1, 1'b0, 1'b0);   // one below MIN_BLOCKS
    run(32'd100, 32'd0, 39, 1'b0, 1'b1);   // abort during step 9
    // Abort together with start while DONE: start must be ignored.
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    check("abort_start_busy", 64'(o_busy), 64'd0);
    check("abort_start_done", 64'(o_done), 64'd1);
    check("abort_start_ckr", 64'(o_ckr_rst), 64'd0);
    run(32'd64, 32'd0, -1, 1'b1, 1'b0);    // restart after abort

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    i_start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
    end
    check("midrun_busy", 64'(o_busy), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_ckr", 64'(o_ckr_rst), 64'd1);
    check("midrst_step", 64'(o_step), 64'd0);
    check("midrst_done", 64'(o_done), 64'd0);
    check("midrst_pass", 64'(o_pass), 64'd0);
    check("midrst_blk", 64'(o_blocks_seen), 64'd0);
    check_idle_outputs("midrst");
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_release_ckr", 64'(o_ckr_rst), 64'd0);
    check("midrst_idle_done", 64'(o_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
